// File: rtl/seq_mem_stream_reader_if.sv
// Bus bundle for the sequential memory reader: the memory read port
// (address, enable, registered data, read-valid) and the outgoing
// valid/ready word stream.
interface seq_mem_stream_reader_if #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
);
  logic [IDX_SIZE-1:0] mem_addr0;
  logic                mem_read_en;
  logic [WIDTH-1:0]    mem_out;
  logic                mem_read_done;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_data;
  logic                out_last;

  // Reader side: drives the memory request and the stream output.
  modport master (
    output mem_addr0, mem_read_en, out_valid, out_data, out_last,
    input  mem_out, mem_read_done, out_ready
  );

  // Memory / consumer side.
  modport slave (
    input  mem_addr0, mem_read_en, out_valid, out_data, out_last,
    output mem_out, mem_read_done, out_ready
  );
endinterface

// File: rtl/seq_mem_stream_reader.sv
// Sequential-read front end for a registered-output memory. On go it reads
// len words starting at base_addr (wrapping at SIZE) and presents them as a
// valid/ready stream, flagging the final word with out_last. A 3-entry
// buffer absorbs the one-cycle memory latency so that a continuously ready
// consumer sees one word per cycle; reads are throttled so words already in
// flight can never overflow the buffer.
module seq_mem_stream_reader #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 16,
  parameter int IDX_SIZE  = 4,
  parameter int LEN_WIDTH = IDX_SIZE + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [IDX_SIZE-1:0]  base_addr,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 done,
  seq_mem_stream_reader_if.master bus
);

  localparam int AW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [IDX_SIZE-1:0]  base_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] issued;
  logic [LEN_WIDTH-1:0] accepted;

  logic [WIDTH-1:0]     buf_mem [3];
  logic [1:0]           wr_ptr, rd_ptr;
  logic [1:0]           occ;

  logic                 push, pop, issue, head_last;

  // Circular index over the three buffer slots.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // (base + offset) mod SIZE; base < SIZE and offset < SIZE while issuing,
  // so a single conditional subtract suffices.
  function automatic logic [IDX_SIZE-1:0] wrap_addr(input logic [IDX_SIZE-1:0]  b,
                                                    input logic [LEN_WIDTH-1:0] off);
    logic [AW-1:0] s;
    s = AW'(b) + AW'(off);
    if (s >= AW'(SIZE)) s = s - AW'(SIZE);
    return s[IDX_SIZE-1:0];
  endfunction

  // Read issue, buffer push/pop and stream outputs.
  always_comb begin
    push          = (state == RUN) & bus.mem_read_done;
    bus.out_valid = (occ != 2'd0);
    pop           = bus.out_valid & bus.out_ready;
    // A read may only go out if the buffer plus the word still in flight
    // leaves room for it.
    issue         = (state == RUN) & (issued < len_q) &
                    ((3'(occ) + 3'(bus.mem_read_done)) < 3'd3);
    bus.mem_read_en = issue;
    bus.mem_addr0   = (state == RUN) ? wrap_addr(base_q, issued) : '0;
    bus.out_data    = buf_mem[rd_ptr];
    head_last       = (accepted + LEN_WIDTH'(1)) == len_q;
    bus.out_last    = bus.out_valid & head_last;
    done            = (state == DONE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: a zero-length request completes immediately; a run ends
  // when the consumer takes the word flagged last.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = (len == '0) ? DONE : RUN;
      RUN:     if (pop && head_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer parameters, counters and buffer bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      accepted <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
    end else begin
      if (state == IDLE && go) begin
        base_q   <= base_addr;
        len_q    <= len;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (issue) issued   <= issued + LEN_WIDTH'(1);
        if (pop)   accepted <= accepted + LEN_WIDTH'(1);
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Buffer storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= bus.mem_out;
  end

  // Sanity checks for illegal requests and overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push && !pop && occ == 2'd3)
        $error("seq_mem_stream_reader: buffer overflow");
      if (state == IDLE && go && len > LEN_WIDTH'(SIZE))
        $error("seq_mem_stream_reader: len %0d exceeds SIZE", len);
    end
  end

endmodule
